uart_sync_fifo: RTL and testbench

Parametrised single-clock FIFO; next generation of the UART transmit-path byte buffer between the host-side write port and the serialiser. Generalises data width and depth, keeps a programmable full threshold, and adds an almost-empty threshold, an occupancy output, a synchronous flush, and sticky overflow/underflow error flags. Read data is first-word-fall-through: the head entry is always presented on `data_out`.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_fifo_ram.sv | 28 ++
 rtl/uart_sync_fifo.sv | 112 +++++++++++
 tb/tb_uart_sync_fifo.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and helpers for the UART transmit-path byte buffer.
package uart_pkg;

    localparam int UART_FIFO_DATA_W = 8;
    localparam int UART_FIFO_ADDR_W = 5;

    // An out-of-range threshold (0 or above depth) means "full at depth".
    function automatic int eff_thres(input int thres, input int depth);
        if (thres < 1 || thres > depth) begin
            return depth;
        end
        return thres;
    endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// FIFO storage: synchronous write, asynchronous read, no reset.
module uart_fifo_ram
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_FIFO_DATA_W,
    parameter int ADDR_W = UART_FIFO_ADDR_W
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with thresholds, flush
// and sticky overflow/underflow flags.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_FIFO_DATA_W,
    parameter int ADDR_W = UART_FIFO_ADDR_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              write_enable,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read_enable,
    input  logic              flush,
    input  logic              clear_err,
    input  logic [ADDR_W:0]   full_thres,
    input  logic [ADDR_W:0]   ae_thres,
    output logic [DATA_W-1:0] data_out,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [ADDR_W:0]   level_q;
    logic [ADDR_W:0]   ft;
    logic              wr_ok;
    logic              rd_ok;
    logic              ovf_set;
    logic              unf_set;
    logic              ovf_q;
    logic              unf_q;

    always_comb begin
        ft = (ADDR_W + 1)'(eff_thres(int'(full_thres), DEPTH));
    end

    // ">=" keeps writes blocked if the threshold drops below the level.
    assign full         = (level_q >= ft);
    assign empty        = (level_q == '0);
    assign almost_empty = (level_q <= ae_thres);
    assign level        = level_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    assign wr_ok   = write_enable & ~full & ~flush;
    assign rd_ok   = read_enable & ~empty & ~flush;
    assign ovf_set = write_enable & full & ~flush;
    assign unf_set = read_enable & empty & ~flush;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr    <= '0;
            rptr    <= '0;
            level_q <= '0;
        end else if (flush) begin
            wptr    <= '0;
            rptr    <= '0;
            level_q <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + ADDR_W'(1);
            end
            if (rd_ok) begin
                rptr <= rptr + ADDR_W'(1);
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   level_q <= level_q + (ADDR_W + 1)'(1);
                2'b01:   level_q <= level_q - (ADDR_W + 1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // A set event in the same cycle beats clear_err.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (clear_err) begin
                ovf_q <= 1'b0;
            end
            if (unf_set) begin
                unf_q <= 1'b1;
            end else if (clear_err) begin
                unf_q <= 1'b0;
            end
        end
    end

    uart_fifo_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clock (clock),
        .we    (wr_ok),
        .waddr (wptr),
        .wdata (data_in),
        .raddr (rptr),
        .rdata (data_out)
    );

endmodule

// File: tb/tb_uart_sync_fifo.sv
// Scoreboard bench for uart_sync_fifo: queue reference model,
// directed scenarios followed by a randomized phase.
module tb_uart_sync_fifo;

    localparam int DEPTH = 32;

    logic       clock;
    logic       reset_n;
    logic       write_enable;
    logic [7:0] data_in;
    logic       read_enable;
    logic       flush;
    logic       clear_err;
    logic [5:0] full_thres;
    logic [5:0] ae_thres;
    logic [7:0] data_out;
    logic       empty;
    logic       full;
    logic       almost_empty;
    logic [5:0] level;
    logic       overflow;
    logic       underflow;

    uart_sync_fifo dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .write_enable (write_enable),
        .data_in      (data_in),
        .read_enable  (read_enable),
        .flush        (flush),
        .clear_err    (clear_err),
        .full_thres   (full_thres),
        .ae_thres     (ae_thres),
        .data_out     (data_out),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .level        (level),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int         errors = 0;
    int         checks = 0;
    bit         done = 0;
    logic [7:0] exp_q[$];
    int         m_level = 0;
    bit         m_ovf = 0;
    bit         m_unf = 0;

    function automatic int eff_ft(input int t);
        return (t == 0 || t > DEPTH) ? DEPTH : t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Monitor: compare outputs with the model, pop on accepted reads,
    // then advance the model to the state after the coming edge.
    initial begin
        forever begin
            @(negedge clock);
            if (reset_n && !done) begin
                bit m_full, m_empty, wr, rd;
                m_full  = m_level >= eff_ft(int'(full_thres));
                m_empty = m_level == 0;
                chk("level", 32'(level), 32'(m_level));
                chk("empty", 32'(empty), 32'(m_empty));
                chk("full", 32'(full), 32'(m_full));
                chk("almost_empty", 32'(almost_empty),
                    32'(m_level <= int'(ae_thres)));
                chk("overflow", 32'(overflow), 32'(m_ovf));
                chk("underflow", 32'(underflow), 32'(m_unf));
                if (m_level > 0) begin
                    chk("data_out", 32'(data_out), 32'(exp_q[0]));
                end
                wr = write_enable && !m_full && !flush;
                rd = read_enable && !m_empty && !flush;
                if (flush) begin
                    exp_q.delete();
                    m_level = 0;
                end else begin
                    if (rd) begin
                        void'(exp_q.pop_front());
                    end
                    m_level = m_level + int'(wr) - int'(rd);
                end
                if (write_enable && m_full && !flush) m_ovf = 1;
                else if (clear_err) m_ovf = 0;
                if (read_enable && m_empty && !flush) m_unf = 1;
                else if (clear_err) m_unf = 0;
            end
        end
    end

    // Stimulus: one cycle of inputs; accepted writes go to the scoreboard.
    task automatic drive(input bit we, input logic [7:0] d, input bit re,
                         input bit fl, input bit ce);
        @(posedge clock);
        #1;
        write_enable = we;
        data_in      = d;
        read_enable  = re;
        flush        = fl;
        clear_err    = ce;
        if (we && !fl && m_level < eff_ft(int'(full_thres))) begin
            exp_q.push_back(d);
        end
    endtask

    task automatic thr(input logic [5:0] f, input logic [5:0] a);
        @(posedge clock);
        #1;
        full_thres   = f;
        ae_thres     = a;
        write_enable = 0;
        read_enable  = 0;
        flush        = 0;
        clear_err    = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 8'h00, 0, 0, 0);
    endtask

    task automatic check_reset_vals();
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_almost_empty", 32'(almost_empty), 32'd1);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
    endtask

    task automatic async_reset();
        @(posedge clock);
        #2;
        reset_n      = 0;
        write_enable = 0;
        read_enable  = 0;
        flush        = 0;
        clear_err    = 0;
        exp_q.delete();
        m_level = 0;
        m_ovf   = 0;
        m_unf   = 0;
        #1;
        check_reset_vals();
        @(posedge clock);
        #2;
        reset_n = 1;
    endtask

    initial begin
        reset_n      = 0;
        write_enable = 0;
        data_in      = 0;
        read_enable  = 0;
        flush        = 0;
        clear_err    = 0;
        full_thres   = 0;
        ae_thres     = 0;
        #3;
        check_reset_vals();
        #9;
        reset_n = 1;

        // Fill to depth, overflow, drain in order, underflow.
        for (int i = 0; i < 33; i++) drive(1, 8'(i), 0, 0, 0);
        for (int i = 0; i < 32; i++) drive(0, 8'h00, 1, 0, 0);
        drive(0, 8'h00, 1, 0, 0);
        drive(0, 8'h00, 0, 0, 1);
        idle(1);

        // Programmable full threshold and error clear.
        thr(6'd4, 6'd0);
        for (int i = 0; i < 6; i++) drive(1, 8'($urandom), 0, 0, 0);
        drive(0, 8'h00, 0, 0, 1);
        idle(1);
        thr(6'd40, 6'd0);
        drive(1, 8'h11, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 8'h00, 1, 0, 0);

        // Steady-state read+write across pointer wrap.
        thr(6'd0, 6'd0);
        for (int i = 0; i < 10; i++) drive(1, 8'($urandom), 0, 0, 0);
        for (int i = 0; i < 40; i++) drive(1, 8'($urandom), 1, 0, 0);
        for (int i = 0; i < 10; i++) drive(0, 8'h00, 1, 0, 0);

        // Almost-empty threshold crossing.
        thr(6'd0, 6'd2);
        for (int i = 0; i < 3; i++) drive(1, 8'($urandom), 0, 0, 0);
        drive(0, 8'h00, 1, 0, 0);
        drive(0, 8'h00, 1, 0, 0);
        drive(0, 8'h00, 1, 0, 0);
        idle(1);

        // Read on empty with a simultaneous write.
        drive(1, 8'hA5, 1, 0, 0);
        idle(1);
        drive(0, 8'h00, 1, 0, 1);

        // Flush beats write; threshold lowered under level.
        for (int i = 0; i < 6; i++) drive(1, 8'($urandom), 0, 0, 0);
        drive(1, 8'h77, 1, 1, 0);
        idle(1);
        for (int i = 0; i < 8; i++) drive(1, 8'($urandom), 0, 0, 0);
        thr(6'd3, 6'd1);
        drive(1, 8'h99, 0, 0, 0);
        drive(0, 8'h00, 1, 0, 1);

        // Async reset mid-stream.
        thr(6'd0, 6'd4);
        for (int i = 0; i < 5; i++) drive(1, 8'($urandom), 1, 0, 0);
        async_reset();
        idle(2);

        // Randomized phase.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 31) == 0) begin
                thr(6'($urandom_range(0, 63)), 6'($urandom_range(0, 33)));
            end else begin
                drive(bit'($urandom_range(0, 99) < 55), 8'($urandom),
                      bit'($urandom_range(0, 99) < 45),
                      bit'($urandom_range(0, 59) == 0),
                      bit'($urandom_range(0, 15) == 0));
            end
        end
        idle(2);
        done = 1;
        @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
